// File: rtl/sq_wave_meter.sv
// sq_wave_meter: synchronises i_x, flags edges (o_rise/o_fall), measures o_period/o_high, counts o_edges, flags o_timeout; i_clr clears measurements; SQW_GLITCH_FILTER_EN adds a FILT_LEN-cycle glitch filter ahead of o_x_sync
module sq_wave_meter #(
  parameter int CNT_W = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_x,
  input  logic             i_clr,
  output logic             o_x_sync,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_edges,
  output logic             o_timeout
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad
    $error("sq_wave_meter: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic x_d, raw, meas, tmo;
  assign raw = sync[SYNC_STAGES-1];
  always_ff @(posedge i_clk)
    sync <= i_rst ? '0 : {sync[SYNC_STAGES-2:0], i_x};
`ifdef SQW_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILT_LEN - 1);
  logic [FW-1:0] fcnt;
  logic flt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flt <= 1'b0;
      fcnt <= '0;
    end else if (raw == flt) fcnt <= '0;
    else if (fcnt == FMAX) begin
      flt <= raw;
      fcnt <= '0;
    end else fcnt <= fcnt + 1'b1;
  end
  assign o_x_sync = flt;
`else
  assign o_x_sync = raw;
`endif
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : nxt;
  always_comb begin
    tmo = state != IDLE && cnt == MAX && !o_rise && !o_fall;
    nxt = i_clr ? IDLE : o_rise ? HIGH : (state == HIGH && o_fall) ? LOW : tmo ? IDLE : state;
  end
  always_comb
    meas = !i_clr && o_rise && state != IDLE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_d <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      o_valid <= 1'b0;
      cnt <= '0;
      o_period <= '0;
      o_high <= '0;
      o_edges <= '0;
      o_timeout <= 1'b0;
    end else begin
      x_d <= o_x_sync;
      o_rise <= o_x_sync & ~x_d;
      o_fall <= ~o_x_sync & x_d;
      o_valid <= meas;
      if (i_clr) begin
        cnt <= '0;
        o_period <= '0;
        o_high <= '0;
        o_edges <= '0;
        o_timeout <= 1'b0;
      end else begin
        cnt <= o_rise ? CNT_W'(1) : cnt == MAX ? cnt : cnt + 1'b1;
        if (meas) o_period <= cnt;
        if (state == HIGH && o_fall) o_high <= cnt;
        if (o_rise) o_edges <= o_edges + 1'b1;
        if (tmo) o_timeout <= 1'b1;
      end
    end
  end
endmodule
